j_wordpair32: RTL and testbench
===============================

# j_wordpair32

Host-side write assembler for the Jerry 32-bit load-enabled registers. It collects two 16-bit bus writes (high half, then low half) into one 32-bit word and queues it in a 2-entry buffer. It drives the downstream register's `d[0:31]` and `ld` inputs with a one-cycle load pulse, and holds words back while the downstream stage is not ready.

## Interface
- No parameters. Word width is fixed at 32 and half width at 16.
- `sys_clk`  in  1  single clock for all state.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  host write strobe, sampled each `sys_clk` edge.
- `wr_hi`  in  1  half select for a write: 1 = high half (bits 16..31), 0 = low half (bits 0..15).
- `wr_data`  in  [0:15]  write data. Bit 0 is the LSB.
- `ld_ok`  in  1  downstream ready; `ld` is only asserted when this is 1.
- `clr_ovf`  in  1  synchronous clear of `ovf`.
- `q_d`  out  [0:31]  word at the buffer head. Bit 0 is the LSB; connects to the register `d`.
- `ld`  out  1  one-cycle load strobe; connects to the register `ld`.
- `busy`  out  1  buffer full; any low-half write in this state is dropped.
- `hi_pend`  out  1  a high half has been written since the last commit.
- `ovf`  out  1  sticky flag: a commit was dropped.
- `count`  out  2  buffer occupancy, 0..2.

## Operation
- **High-half latch:** `wr_en & wr_hi` loads `hi_latch <= wr_data` and sets `hi_pend`. The latch is sticky and keeps its value across commits.
- **Commit:** `wr_en & ~wr_hi` forms `{hi_latch, wr_data}`, with `hi_latch` in bits 16..31, and pushes it into the buffer. `hi_pend` clears.
  - A commit with `hi_pend = 0` still succeeds and reuses the last `hi_latch` value.
- **High-half state machine:**
  - `HI_IDLE` goes to `HI_HELD` on a high write.
  - `HI_HELD` returns to `HI_IDLE` on a commit, including a dropped commit.
  - A high write while in `HI_HELD` overwrites the latch and stays in `HI_HELD`.
  - `hi_pend` = (state == `HI_HELD`).
- **Buffer:** 2-entry FIFO with read pointer, write pointer and count.
  - `ld = (count != 0) & ld_ok` (combinational).
  - `q_d` = head entry while `count != 0`, otherwise 0.
  - Each cycle with `ld` = 1 pops one entry.
- **Full:** `busy = (count == 2)`.
  - A commit while `busy` is dropped: no push, `ovf` is set, `hi_pend` still clears.
  - A commit in the same cycle as a pop while full is still dropped, because `busy` is evaluated before the pop.
- **Simultaneous push and pop** with count 1: count stays 1, and the new word becomes the head on the next cycle.
- **`ovf`:** set on a drop, cleared by `clr_ovf`. If both happen in the same cycle, set wins.
- **High write in the same cycle as a pop:** independent; both take effect.
- **Reset values (asynchronous, `rst` = 1):**
  - `hi_latch` = 0, state = `HI_IDLE`, pointers = 0, `count` = 0.
  - Outputs: `q_d` = 0, `ld` = 0, `busy` = 0, `hi_pend` = 0, `ovf` = 0.
  - Buffered words are discarded. A reset mid-sequence loses any pending high half.

## Timing
- Commit at edge N with an empty buffer and `ld_ok` = 1: `ld` is high during cycle N+1 with `q_d` valid; the pop occurs at edge N+1.
- `ld_ok` low: the word is held and `ld` stays low. `ld` rises in the same cycle that `ld_ok` rises, since `ld` is combinational from registers and `ld_ok`.
- Back-to-back commits with `ld_ok` = 1: one `ld` per cycle. `count` never exceeds 1, so the block sustains full rate.
- `busy` is registered-state derived, with no combinational path from `wr_en`.

## Structure
- Constants `JW_HALF = 16`, `JW_WORD = 32`, `JW_DEPTH = 2` and the high-half state encoding (`HI_IDLE`, `HI_HELD`) go in the shared Jerry package.
- One sub-module: `j_fifo2x32`, a 2-entry FIFO with push, pop, head, count and full.
  - The top level holds the high-half latch, the state machine, drop and `ovf` logic, and the `ld` gating.

## Test plan
- **Reset:** assert `rst` mid-stream with `count` = 2 → all outputs 0 immediately; `count` = 0; no `ld` after release.
- **Basic commit:** hi `16'h1234`, then lo `16'h5678` with `ld_ok` = 1 → `ld` pulses one cycle after the lo write; `q_d` = `32'h12345678`; `hi_pend` is 1 between the writes and 0 after.
- **Sticky high half:** hi `16'hAAAA`, lo `16'h0001`, lo `16'h0002` → two loads, `32'hAAAA0001` then `32'hAAAA0002`.
- **Backpressure and overflow:** `ld_ok` = 0, commit three words → `count` = 2, `busy` = 1, third word dropped, `ovf` = 1. Raise `ld_ok` → exactly two `ld` pulses, first two words in order. `clr_ovf` → `ovf` = 0.
- **Push and pop together:** `ld_ok` = 1 with continuous commits of `0x1..0x4` (hi fixed at 0) → four consecutive `ld` pulses, `count` never above 1, no drops.
- **Set/clear collision:** a drop in the same cycle as `clr_ovf` → `ovf` = 1.

Source files
------------

// File: rtl/j_wordpair32_pkg.sv
// Shared Jerry constants and types for the 32-bit word-pair write assembler.
// The high-half state encoding lives here so the top and the bench agree on it.
package j_wordpair32_pkg;

    localparam int JW_HALF  = 16;
    localparam int JW_WORD  = 32;
    localparam int JW_DEPTH = 2;
    localparam int JW_CNT_W = 2;

    typedef logic [JW_HALF-1:0]  half_t;
    typedef logic [JW_WORD-1:0]  word_t;
    typedef logic [JW_CNT_W-1:0] cnt_t;

    typedef enum logic {
        HI_IDLE = 1'b0,
        HI_HELD = 1'b1
    } hi_state_e;

    // High half occupies bits 16..31, low half bits 0..15.
    function automatic word_t jw_join(input half_t hi, input half_t lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/j_wordpair32_fifo2x32.sv
// Two-entry word FIFO: registered pointers and occupancy, head forced to zero when empty.
// Pushes into a full FIFO and pops from an empty one are ignored.
module j_fifo2x32
    import j_wordpair32_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  push,
    input  logic  pop,
    input  word_t din,
    output word_t head,
    output cnt_t  count,
    output logic  full,
    output logic  empty
);

    logic  wr_ptr_q, wr_ptr_d;
    logic  rd_ptr_q, rd_ptr_d;
    cnt_t  count_q, count_d;
    word_t mem_q [JW_DEPTH];

    logic do_push;
    logic do_pop;

    assign full    = (count_q == cnt_t'(JW_DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = ~wr_ptr_q;
        if (do_pop)  rd_ptr_d = ~rd_ptr_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; head is gated by empty, so stale data never escapes.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    assign head  = empty ? '0 : mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/j_wordpair32.sv
// Host-side write assembler: pairs high/low 16-bit writes into a 32-bit word,
// buffers up to two words and presents them to a load-enabled register via d/ld.
module j_wordpair32
    import j_wordpair32_pkg::*;
(
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              wr_hi,
    input  logic [JW_HALF-1:0] wr_data,
    input  logic              ld_ok,
    input  logic              clr_ovf,
    output logic [JW_WORD-1:0] q_d,
    output logic              ld,
    output logic              busy,
    output logic              hi_pend,
    output logic              ovf,
    output logic [JW_CNT_W-1:0] count
);

    hi_state_e state_q;
    half_t     hi_latch_q;
    logic      hi_pend_q;
    logic      ovf_q, ovf_d;

    logic  hi_wr;
    logic  commit;
    logic  drop;
    logic  push;
    logic  pop;
    logic  fifo_full;
    logic  fifo_empty;
    word_t fifo_head;
    cnt_t  fifo_count;

    assign hi_wr  = wr_en & wr_hi;
    assign commit = wr_en & ~wr_hi;
    // Fullness is the pre-edge occupancy, so a commit racing a pop while full is still dropped.
    assign drop   = commit & fifo_full;
    assign push   = commit & ~fifo_full;
    assign pop    = ld;

    j_fifo2x32 u_fifo (
        .clk   (sys_clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (jw_join(hi_latch_q, wr_data)),
        .head  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // The latch is sticky: only a high write changes it, commits just reuse it.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q    <= HI_IDLE;
            hi_pend_q  <= 1'b0;
            hi_latch_q <= '0;
        end else begin
            if (hi_wr) hi_latch_q <= wr_data;
            unique case (state_q)
                HI_IDLE: begin
                    if (hi_wr) begin
                        state_q   <= HI_HELD;
                        hi_pend_q <= 1'b1;
                    end
                end
                HI_HELD: begin
                    if (commit) begin
                        state_q   <= HI_IDLE;
                        hi_pend_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= HI_IDLE;
                    hi_pend_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        if (drop)         ovf_d = 1'b1;
        else if (clr_ovf) ovf_d = 1'b0;
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
    end

    assign ld      = ~fifo_empty & ld_ok;
    assign q_d     = fifo_head;
    assign busy    = fifo_full;
    assign hi_pend = hi_pend_q;
    assign ovf     = ovf_q;
    assign count   = fifo_count;

endmodule

// File: tb/tb_j_wordpair32.sv
// Randomized and directed bench for j_wordpair32 against a queue-based reference model.
module tb_j_wordpair32;

    logic        sys_clk;
    logic        rst;
    logic        wr_en;
    logic        wr_hi;
    logic [15:0] wr_data;
    logic        ld_ok;
    logic        clr_ovf;
    logic [31:0] q_d;
    logic        ld;
    logic        busy;
    logic        hi_pend;
    logic        ovf;
    logic [1:0]  count;

    j_wordpair32 dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_hi   (wr_hi),
        .wr_data (wr_data),
        .ld_ok   (ld_ok),
        .clr_ovf (clr_ovf),
        .q_d     (q_d),
        .ld      (ld),
        .busy    (busy),
        .hi_pend (hi_pend),
        .ovf     (ovf),
        .count   (count)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: buffer contents as a plain queue.
    logic [31:0] m_q [$];
    logic [15:0] m_hi;
    logic        m_pend;
    logic        m_ovf;

    logic [31:0] ld_log [$];
    int          max_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_q.delete();
        m_hi   = '0;
        m_pend = 1'b0;
        m_ovf  = 1'b0;
    endfunction

    // Called at posedge+1; applies inputs, checks at negedge, advances model across the edge.
    task automatic step(input logic en, input logic hi, input logic [15:0] d,
                        input logic ok, input logic clr);
        logic        e_ld;
        logic        drop;
        logic [31:0] e_q;
        wr_en   = en;
        wr_hi   = hi;
        wr_data = d;
        ld_ok   = ok;
        clr_ovf = clr;
        @(negedge sys_clk);
        e_ld = (m_q.size() != 0) && ok;
        e_q  = (m_q.size() != 0) ? m_q[0] : 32'h0;
        check("count",   32'(count),   32'(m_q.size()));
        check("busy",    32'(busy),    32'(m_q.size() == 2));
        check("ld",      32'(ld),      32'(e_ld));
        check("q_d",     q_d,          e_q);
        check("hi_pend", 32'(hi_pend), 32'(m_pend));
        check("ovf",     32'(ovf),     32'(m_ovf));
        if (ld) ld_log.push_back(q_d);
        if (int'(count) > max_cnt) max_cnt = int'(count);
        @(posedge sys_clk);
        drop = en && !hi && (m_q.size() == 2);
        if (e_ld) void'(m_q.pop_front());
        if (en && hi) begin
            m_hi   = d;
            m_pend = 1'b1;
        end else if (en) begin
            m_pend = 1'b0;
            if (!drop) m_q.push_back({m_hi, d});
        end
        if (drop)     m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        #1;
    endtask

    task automatic idle(input logic ok, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, ok, 1'b0);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_hi = 1'b0; wr_data = '0; ld_ok = 1'b1; clr_ovf = 1'b0;
        model_reset();
        max_cnt = 0;
        repeat (2) @(posedge sys_clk);
        #1;
        check("rst_q_d", q_d, 32'h0);
        check("rst_ld", 32'(ld), 32'h0);
        check("rst_count", 32'(count), 32'h0);
        check("rst_hi_pend", 32'(hi_pend), 32'h0);
        rst = 1'b0;
        idle(1'b1, 2);

        // Basic commit.
        ld_log.delete();
        step(1'b1, 1'b1, 16'h1234, 1'b1, 1'b0);
        step(1'b1, 1'b0, 16'h5678, 1'b1, 1'b0);
        idle(1'b1, 2);
        check("basic_nld", 32'(ld_log.size()), 32'd1);
        if (ld_log.size() > 0) check("basic_word", ld_log[0], 32'h12345678);

        // Sticky high half.
        ld_log.delete();
        step(1'b1, 1'b1, 16'hAAAA, 1'b1, 1'b0);
        step(1'b1, 1'b0, 16'h0001, 1'b1, 1'b0);
        step(1'b1, 1'b0, 16'h0002, 1'b1, 1'b0);
        idle(1'b1, 2);
        check("sticky_nld", 32'(ld_log.size()), 32'd2);
        if (ld_log.size() > 1) begin
            check("sticky_w0", ld_log[0], 32'hAAAA0001);
            check("sticky_w1", ld_log[1], 32'hAAAA0002);
        end

        // Backpressure and overflow.
        ld_log.delete();
        step(1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) step(1'b1, 1'b0, 16'(i), 1'b0, 1'b0);
        idle(1'b0, 2);
        check("bp_count", 32'(count), 32'd2);
        check("bp_busy", 32'(busy), 32'd1);
        check("bp_ovf", 32'(ovf), 32'd1);
        idle(1'b1, 4);
        check("bp_nld", 32'(ld_log.size()), 32'd2);
        if (ld_log.size() > 1) begin
            check("bp_w0", ld_log[0], 32'hBEEF0001);
            check("bp_w1", ld_log[1], 32'hBEEF0002);
        end
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        check("bp_clr", 32'(ovf), 32'd0);

        // Push and pop together at full rate.
        ld_log.delete();
        max_cnt = 0;
        step(1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 16'(i), 1'b1, 1'b0);
        idle(1'b1, 2);
        check("pp_nld", 32'(ld_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < ld_log.size(); i++) check("pp_word", ld_log[i], 32'(i + 1));
        check("pp_maxcnt", 32'(max_cnt), 32'd1);
        check("pp_ovf", 32'(ovf), 32'd0);

        // Set/clear collision, leaving the buffer full.
        step(1'b1, 1'b0, 16'h0011, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'h0022, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'h0033, 1'b0, 1'b1);
        check("coll_ovf", 32'(ovf), 32'd1);
        step(1'b1, 1'b1, 16'h7777, 1'b0, 1'b0);

        // Asynchronous reset mid-stream with count = 2.
        ld_ok = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("arst_q_d", q_d, 32'h0);
        check("arst_ld", 32'(ld), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_hi_pend", 32'(hi_pend), 32'h0);
        check("arst_ovf", 32'(ovf), 32'h0);
        check("arst_count", 32'(count), 32'h0);
        model_reset();
        @(posedge sys_clk);
        #1 rst = 1'b0;
        ld_log.delete();
        idle(1'b1, 3);
        check("arst_nld", 32'(ld_log.size()), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            logic en, hi, ok, clr;
            en  = ($urandom_range(0, 3) != 0);
            hi  = ($urandom_range(0, 2) == 0);
            ok  = ($urandom_range(0, 1) == 1);
            clr = ($urandom_range(0, 9) == 0);
            step(en, hi, 16'($urandom), ok, clr);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
